// File: rtl/uart_pkg.sv
// Purpose: default baud constants shared by the UART RX, TX and baud generator.
// Latency: none (constants only).
// Backpressure: none.
package uart_pkg;

  localparam int UART_DIV_W      = 16;
  localparam int UART_FRAC_W     = 4;
  localparam int UART_OSR        = 16;
  localparam int UART_RESET_INT  = 54;
  localparam int UART_RESET_FRAC = 0;

  // Smallest integer divisor that still gives a tick period of two or more cycles.
  localparam int UART_MIN_DIV    = 2;

endpackage

// File: rtl/baud_frac_acc.sv
// Purpose: fractional divider core; counts int_a (+1 on fractional carry) cycles per raw tick.
// Latency: tick is registered, high the cycle after the terminal edge; hit is the same-cycle terminal flag.
// Backpressure: none; en low freezes the counters, clr realigns the phase.
// Ports: clk, reset (async active-low), en, clr, int_a/frac_a (active divisor),
//        hit (comb: this edge is a tick edge), tick (registered strobe).
module baud_frac_acc #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  int_a,
  input  logic [FRAC_W-1:0] frac_a,
  output logic              hit,
  output logic              tick
);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [DIV_W:0]    term;
  logic [FRAC_W:0]   sum;

  // One extra bit so int_a = max with extra = 1 does not wrap.
  assign term = {1'b0, int_a} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, extra};
  assign sum  = {1'b0, acc} + {1'b0, frac_a};

  // >= rather than == so a divisor that shrinks while disabled ends the
  // period instead of letting cnt run round the whole counter range.
  assign hit  = en && !clr && ({1'b0, cnt} >= term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
      tick  <= 1'b0;
    end else if (!en) begin
      tick  <= 1'b0;
    end else if (hit) begin
      cnt          <= '0;
      tick         <= 1'b1;
      {extra, acc} <= sum;
    end else begin
      cnt   <= cnt + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Purpose: fractional baud generator: oversample tick plus bit_tick every OSR ticks, double-buffered divisor.
// Latency: all outputs registered; a loaded divisor takes effect from the period after the next tick.
// Backpressure: none; en low freezes state, clr realigns phase, bad loads pulse cfg_err.
// Ports: clk, reset (async active-low), en, clr, load, dvsr_int, dvsr_frac,
//        tick, bit_tick, cfg_err (all outputs one-cycle registered strobes).
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W,
  parameter int FRAC_W     = UART_FRAC_W,
  parameter int OSR        = UART_OSR,
  parameter int RESET_INT  = UART_RESET_INT,
  parameter int RESET_FRAC = UART_RESET_FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [DIV_W-1:0]  dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  output logic              tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int OSR_W = $clog2(OSR);

  logic [DIV_W-1:0]  int_a, int_s;
  logic [FRAC_W-1:0] frac_a, frac_s;
  logic              pend;
  logic [OSR_W-1:0]  osr_cnt;
  logic              hit;
  logic              load_ok, load_bad, apply_pend;

  baud_frac_acc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (clr),
    .int_a  (int_a),
    .frac_a (frac_a),
    .hit    (hit),
    .tick   (tick)
  );

  assign load_ok    = load && (dvsr_int >= DIV_W'(UART_MIN_DIV));
  assign load_bad   = load && !load_ok;
  // The shadow is swapped in at a period boundary, or while frozen (no period in flight).
  assign apply_pend = pend && (hit || (!clr && !en));

  // Divisor double buffer and load error strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_a   <= DIV_W'(RESET_INT);
      frac_a  <= FRAC_W'(RESET_FRAC);
      int_s   <= DIV_W'(RESET_INT);
      frac_s  <= FRAC_W'(RESET_FRAC);
      pend    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= load_bad;
      if (load_ok && hit) begin
        // Load on a tick edge: the next period already uses the new divisor.
        int_a  <= dvsr_int;
        frac_a <= dvsr_frac;
        pend   <= 1'b0;
      end else begin
        if (apply_pend) begin
          int_a  <= int_s;
          frac_a <= frac_s;
        end
        if (load_ok) begin
          int_s  <= dvsr_int;
          frac_s <= dvsr_frac;
          pend   <= 1'b1;
        end else if (apply_pend) begin
          pend   <= 1'b0;
        end
      end
    end
  end

  // Oversample divider: bit_tick coincides with every OSR-th tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      osr_cnt  <= '0;
      bit_tick <= 1'b0;
    end else if (clr) begin
      osr_cnt  <= '0;
      bit_tick <= 1'b0;
    end else if (hit) begin
      if (osr_cnt == OSR_W'(OSR - 1)) begin
        osr_cnt  <= '0;
        bit_tick <= 1'b1;
      end else begin
        osr_cnt  <= osr_cnt + OSR_W'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Purpose: self-checking bench for baud_gen_frac; expected tick cycles are queued as stimulus is planned.
// Latency: n/a.
// Backpressure: n/a.
module tb_baud_gen_frac;

  localparam int OSR = 16;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic        load;
  logic [15:0] dvsr_int;
  logic [3:0]  dvsr_frac;
  logic        tick;
  logic        bit_tick;
  logic        cfg_err;

  typedef struct {
    int t;
    bit bt;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   next_t  = 0;
  int   tick_no = 0;
  int   base    = 0;

  baud_gen_frac dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .dvsr_int  (dvsr_int),
    .dvsr_frac (dvsr_frac),
    .tick      (tick),
    .bit_tick  (bit_tick),
    .cfg_err   (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: sample 1ns after each rising edge and match every strobe against the queue.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (tick || bit_tick) begin
      if (sb.size() == 0) begin
        chk("spurious_tick", int'(tick), 0);
        chk("spurious_bit_tick", int'(bit_tick), 0);
      end else begin
        e = sb.pop_front();
        chk("tick_cycle", cyc, e.t);
        chk("tick_high", int'(tick), 1);
        chk("bit_tick", int'(bit_tick), int'(e.bt));
      end
    end
  end

  task automatic start_run();
    next_t  = cyc;
    tick_no = 0;
  endtask

  task automatic push_p(input int p);
    exp_t e;
    next_t  += p;
    tick_no++;
    e.t  = next_t;
    e.bt = ((tick_no % OSR) == 0);
    sb.push_back(e);
  endtask

  task automatic run_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Load while disabled, then one more frozen edge moves shadow to active.
  task automatic set_div(input int i, input int f);
    load      = 1'b1;
    dvsr_int  = 16'(i);
    dvsr_frac = 4'(f);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic finish_phase(input string tag);
    run_until(next_t);
    en = 1'b0;
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int frac_tbl[12];
    frac_tbl = '{10, 10, 11, 10, 11, 10, 11, 10, 11, 10, 11, 10};
    reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    dvsr_int = '0; dvsr_frac = '0;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    reset = 1'b1;
    @(negedge clk);

    // Defaults: 54-cycle ticks, bit_tick on every 16th.
    en = 1'b1;
    start_run();
    for (int k = 0; k < 32; k++) push_p(54);
    finish_phase("p1_all_ticks_seen");

    // Divisor 10 + 8/16: 10,10,11,10,11,...
    set_div(10, 8);
    clr_pulse();
    en = 1'b1;
    start_run();
    foreach (frac_tbl[k]) push_p(frac_tbl[k]);
    finish_phase("p2_all_ticks_seen");

    // Load 20 mid-period: current period keeps 54, then 20s.
    set_div(54, 0);
    clr_pulse();
    en = 1'b1;
    start_run();
    base = cyc;
    push_p(54);
    for (int k = 0; k < 5; k++) push_p(20);
    run_until(base + 29);
    load = 1'b1; dvsr_int = 16'd20; dvsr_frac = 4'd0;
    @(negedge clk);
    load = 1'b0;
    finish_phase("p3_all_ticks_seen");

    // Seven-cycle enable gap inside the 16th period; osr position must survive.
    set_div(54, 0);
    clr_pulse();
    en = 1'b1;
    start_run();
    base = cyc;
    for (int k = 0; k < 15; k++) push_p(54);
    push_p(61);
    push_p(54);
    run_until(base + 830);
    en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    finish_phase("p4_all_ticks_seen");

    // Rejected load: cfg_err pulse, period unchanged.
    clr_pulse();
    en = 1'b1;
    start_run();
    base = cyc;
    for (int k = 0; k < 3; k++) push_p(54);
    run_until(base + 10);
    chk("cfg_err_idle", int'(cfg_err), 0);
    load = 1'b1; dvsr_int = 16'd1; dvsr_frac = 4'd3;
    @(negedge clk);
    chk("cfg_err_pulse", int'(cfg_err), 1);
    load = 1'b0;
    @(negedge clk);
    chk("cfg_err_clears", int'(cfg_err), 0);
    finish_phase("p5_all_ticks_seen");

    // clr at cycle 40, pending load of 20, then reset while tick is high.
    clr_pulse();
    en = 1'b1;
    start_run();
    base = cyc;
    run_until(base + 39);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    next_t  = base + 40;
    tick_no = 0;
    push_p(54);
    run_until(base + 50);
    load = 1'b1; dvsr_int = 16'd20; dvsr_frac = 4'd0;
    @(negedge clk);
    load = 1'b0;
    run_until(base + 94);
    chk("tick_before_reset", int'(tick), 1);
    reset = 1'b0;
    #1;
    chk("reset_tick_async", int'(tick), 0);
    chk("reset_bit_tick_async", int'(bit_tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start_run();
    push_p(54);
    push_p(54);
    finish_phase("p6_all_ticks_seen");
    chk("final_cfg_err", int'(cfg_err), 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
